aes_stream_adapter: RTL and testbench

Word-stream front/back end for the 128-bit AES core (`AES_top`). The block sits directly upstream of the core and also collects its result.
- Accepts plaintext as four 32-bit words on a valid/ready stream and holds the 128-bit key in a small write port.
- Issues the core's one-cycle start pulse, tracks the core's busy flag, then captures the ciphertext.
- Returns the ciphertext as four 32-bit words on a valid/ready output stream.
- Guards against a core that never starts or never finishes with a per-phase watchdog.

---
 rtl/aes_stream_pkg.sv | 30 +++
 rtl/aes_stream_adapter_if.sv | 26 ++
 rtl/aes_word_serializer.sv | 35 +++
 rtl/aes_stream_adapter.sv | 164 ++++++++++++++++
 tb/tb_aes_stream_adapter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES word-stream adapter.
package aes_stream_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_W         = 128;
    localparam int WORD_BITS       = BLOCK_W / WORDS_PER_BLOCK;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_COLLECT    = 3'd0,
        ST_TRIG       = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_EMIT       = 3'd4
    } state_t;

    // Word idx of a 128-bit block; word 0 is the most significant.
    function automatic logic [WORD_BITS-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                        input logic [1:0]         idx);
        logic [WORD_BITS-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_stream_adapter_if.sv
// Plaintext input stream and ciphertext output stream of the adapter.
// Handshake: a word transfers on a rising clk edge where valid && ready are
// both 1; once valid is raised, the source holds valid and data unchanged
// until that transfer, and ready may depend on nothing but sink state.
interface aes_stream_adapter_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    // Stream producer/consumer side (testbench or upstream logic).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Adapter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_word_serializer.sv
// Holds one 128-bit result and emits it as four words, MSW first.
module aes_word_serializer
    import aes_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [BLOCK_W-1:0]   load_data,
    input  logic                 en,
    input  logic                 ready,
    output logic                 valid,
    output logic [WORD_BITS-1:0] data,
    output logic                 done
);
    logic [BLOCK_W-1:0] res_q;
    logic [1:0]         cnt_q;

    // Result register, written only on the capture edge.
    always_ff @(posedge clk) begin
        if (reset) res_q <= '0;
        else if (load) res_q <= load_data;
    end

    // Word pointer advances per accepted word and wraps after word 3.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else if (valid && ready) cnt_q <= cnt_q + 2'd1;
    end

    // Data is a pure function of registers, so it holds while stalled.
    assign valid = en;
    assign data  = block_word(res_q, cnt_q);
    assign done  = valid && ready && (cnt_q == 2'd3);

endmodule

// File: rtl/aes_stream_adapter.sv
// Word-stream front/back end for the AES core: collects a plaintext block,
// pulses the core start, watches busy with a per-phase watchdog, then
// returns the ciphertext word by word.
module aes_stream_adapter
    import aes_stream_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_stream_adapter_if.slave  sif,
    input  logic                 key_wr,
    input  logic [1:0]           key_addr,
    input  logic [WORD_W-1:0]    key_wdata,
    output logic                 err,
    input  logic                 err_clr,
    output logic                 sample_trig_top,
    output logic [BLOCK_W-1:0]   TOP_DATA,
    output logic [BLOCK_W-1:0]   TOP_key,
    input  logic [BLOCK_W-1:0]   data_out_TOP,
    input  logic                 busy_TOP,
    output state_t               state_dbg
);
    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_TOP = WD_W'(TIMEOUT);

    state_t            state_q, state_n;
    logic [1:0]        in_cnt_q;
    logic [WORD_W-1:0] blk_q [WORDS_PER_BLOCK];
    logic [WORD_W-1:0] key_q [WORDS_PER_BLOCK];
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_plus;
    logic              wd_hit;
    logic              err_q;

    logic              in_ready_c;
    logic              trig_c;
    logic              in_fire;
    logic              wd_clr;
    logic              wd_inc;
    logic              err_set;
    logic              capture;
    logic              ser_en;
    logic              ser_valid;
    logic              ser_done;
    logic [WORD_W-1:0] ser_data;

    assign in_fire = sif.in_valid && in_ready_c;
    assign wd_plus = wd_q + 1'b1;
    assign wd_hit  = (wd_plus == WD_TOP);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_COLLECT;
        else       state_q <= state_n;
    end

    // Next state and per-state controls.
    always_comb begin
        state_n    = state_q;
        in_ready_c = 1'b0;
        trig_c     = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        err_set    = 1'b0;
        capture    = 1'b0;
        ser_en     = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                in_ready_c = 1'b1;
                if (sif.in_valid && in_cnt_q == 2'd3) state_n = ST_TRIG;
            end
            ST_TRIG: begin
                trig_c  = 1'b1;
                wd_clr  = 1'b1;
                state_n = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (busy_TOP) begin
                    wd_clr  = 1'b1;
                    state_n = ST_WAIT_DONE;
                end else if (wd_hit) begin
                    err_set = 1'b1;
                    state_n = ST_COLLECT;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy_TOP) begin
                    capture = 1'b1;
                    state_n = ST_EMIT;
                end else if (wd_hit) begin
                    err_set = 1'b1;
                    state_n = ST_COLLECT;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ST_EMIT: begin
                ser_en = 1'b1;
                if (ser_done) state_n = ST_COLLECT;
            end
            default: state_n = ST_COLLECT;
        endcase
    end

    // Plaintext word counter and block register; only written while collecting.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q <= '0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) blk_q[i] <= '0;
        end else if (in_fire) begin
            blk_q[in_cnt_q] <= sif.in_data;
            in_cnt_q        <= in_cnt_q + 2'd1;
        end
    end

    // Key register; writes outside COLLECT are dropped so the core sees a stable key.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) key_q[i] <= '0;
        end else if (key_wr && state_q == ST_COLLECT) begin
            key_q[key_addr] <= key_wdata;
        end
    end

    // Saturating watchdog shared by both wait phases.
    always_ff @(posedge clk) begin
        if (reset)                          wd_q <= '0;
        else if (wd_clr)                    wd_q <= '0;
        else if (wd_inc && wd_q != WD_TOP)  wd_q <= wd_plus;
    end

    // Sticky error; a timeout in the same cycle wins over a clear.
    always_ff @(posedge clk) begin
        if (reset)        err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
        else if (err_clr) err_q <= 1'b0;
    end

    aes_word_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (capture),
        .load_data (data_out_TOP),
        .en        (ser_en),
        .ready     (sif.out_ready),
        .valid     (ser_valid),
        .data      (ser_data),
        .done      (ser_done)
    );

    assign sif.in_ready    = in_ready_c;
    assign sif.out_valid   = ser_valid;
    assign sif.out_data    = ser_data;
    assign sample_trig_top = trig_c;
    assign TOP_DATA        = {blk_q[0], blk_q[1], blk_q[2], blk_q[3]};
    assign TOP_key         = {key_q[0], key_q[1], key_q[2], key_q[3]};
    assign err             = err_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Bench for aes_stream_adapter with a behavioural AES core stub.
module tb_aes_stream_adapter;
    import aes_stream_pkg::*;

    localparam int TB_TIMEOUT  = 8;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_DEAD   = 1;
    localparam int MODE_STUCK  = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_wr = 1'b0;
    logic [1:0]   key_addr = '0;
    logic [31:0]  key_wdata = '0;
    logic         err;
    logic         err_clr = 1'b0;
    logic         sample_trig_top;
    logic [127:0] TOP_DATA, TOP_key;
    logic [127:0] core_out;
    logic         core_busy;
    state_t       state_dbg;

    always #5 clk = ~clk;

    aes_stream_adapter_if #(.WORD_W(32)) sif ();

    aes_stream_adapter #(.WORD_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .sif             (sif),
        .key_wr          (key_wr),
        .key_addr        (key_addr),
        .key_wdata       (key_wdata),
        .err             (err),
        .err_clr         (err_clr),
        .sample_trig_top (sample_trig_top),
        .TOP_DATA        (TOP_DATA),
        .TOP_key         (TOP_key),
        .data_out_TOP    (core_out),
        .busy_TOP        (core_busy),
        .state_dbg       (state_dbg)
    );

    // ---------------- counters and checker ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- AES-128 reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (v != 0 && gm(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- core stub ----------------
    int core_mode = MODE_NORMAL;
    int core_lat  = -1;
    int core_cnt;
    bit core_junk;

    // Busy one cycle after the pulse, result appears as busy drops and is
    // scrambled one cycle later so a late capture is visible.
    always @(posedge clk) begin
        if (reset) begin
            core_busy <= 1'b0;
            core_out  <= '0;
            core_cnt  <= 0;
            core_junk <= 1'b0;
        end else begin
            core_junk <= 1'b0;
            if (core_junk) core_out <= {$urandom, $urandom, $urandom, $urandom};
            if (sample_trig_top && core_mode != MODE_DEAD) begin
                core_busy <= 1'b1;
                core_cnt  <= (core_lat >= 0) ? core_lat : int'($urandom_range(0, 4));
                core_out  <= {$urandom, $urandom, $urandom, $urandom};
            end else if (core_busy && core_mode == MODE_NORMAL) begin
                if (core_cnt == 0) begin
                    core_busy <= 1'b0;
                    core_out  <= aes_enc(TOP_key, TOP_DATA);
                    core_junk <= 1'b1;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0]  exp_q [$];
    logic [31:0]  bench_key [4];
    logic [127:0] last_blk = '0;
    int           trig_cnt = 0;
    bit           prev_stall = 1'b0;
    bit           prev_trig = 1'b0;
    logic [31:0]  prev_data = '0;
    bit           rdy_rand = 1'b0;

    function automatic logic [127:0] model_key();
        return {bench_key[0], bench_key[1], bench_key[2], bench_key[3]};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_trig  = 1'b0;
        end else begin
            if (sif.out_valid) check("no_overlap", sif.in_ready, 1'b0);
            if (prev_stall) begin
                check("stall_valid", sif.out_valid, 1'b1);
                check("stall_data", sif.out_data, prev_data);
            end
            if (sample_trig_top) begin
                trig_cnt++;
                check("trig_single", prev_trig, 1'b0);
            end
            if (sif.out_valid && sif.out_ready) begin
                check("out_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("out_word", sif.out_data, exp_q.pop_front());
                last_blk = {last_blk[95:0], sif.out_data};
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_data  = sif.out_data;
            prev_trig  = sample_trig_top;
        end
    end

    // Consumer ready: always 1, or a fair coin per cycle when stalls are wanted.
    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            sif.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic write_key(input logic [1:0] idx, input logic [31:0] val, input bit taken);
        key_wr = 1'b1; key_addr = idx; key_wdata = val;
        @(posedge clk); #1;
        key_wr = 1'b0;
        if (taken) bench_key[idx] = val;
    endtask

    task automatic send_block(input logic [127:0] pt, input bit gaps, input bit push, input int nw);
        if (push) begin
            logic [127:0] e = aes_enc(model_key(), pt);
            for (int i = 0; i < 4; i++) exp_q.push_back(e[127-32*i -: 32]);
        end
        for (int w = 0; w < nw; w++) begin
            bit acc = 1'b0;
            int n = 0;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            sif.in_valid = 1'b1;
            sif.in_data  = pt[127-32*w -: 32];
            while (!acc && n < 200) begin
                @(negedge clk);
                acc = sif.in_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) check("in_accept_timeout", acc, 1'b1);
            sif.in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || state_dbg != ST_COLLECT) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input state_t st, input string tag);
        int n = 0;
        @(negedge clk);
        while (state_dbg != st && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, state_dbg, st);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) bench_key[i] = '0;
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, sif.in_ready, 1'b1);
        check({tag, "_out_valid"}, sif.out_valid, 1'b0);
        check({tag, "_top_key"}, TOP_key, '0);
        check({tag, "_top_data"}, TOP_DATA, '0);
        check({tag, "_state"}, state_dbg, ST_COLLECT);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        logic [127:0] pt;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        for (int i = 0; i < 4; i++) bench_key[i] = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", sif.in_ready, 1'b1);
        check("rst_out_valid", sif.out_valid, 1'b0);
        check("rst_trig", sample_trig_top, 1'b0);
        check("rst_out_data", sif.out_data, '0);
        check("rst_top_data", TOP_DATA, '0);
        check("rst_top_key", TOP_key, '0);
        check("rst_err", err, 1'b0);
        check("rst_state", state_dbg, ST_COLLECT);
        @(posedge clk); #1;

        // FIPS-197 vector
        for (int i = 0; i < 4; i++) write_key(2'(i), FIPS_KEY[127-32*i -: 32], 1'b1);
        check("fips_top_key", TOP_key, model_key());
        t0 = trig_cnt;
        send_block(FIPS_PT, 1'b0, 1'b1, 4);
        check("fips_top_data", TOP_DATA, FIPS_PT);
        drain("fips");
        check("fips_ct", last_blk, FIPS_CT);
        check("fips_trig_count", trig_cnt - t0, 1);
        check("fips_err", err, 1'b0);

        // Backpressure and input gaps over two back-to-back blocks
        rdy_rand = 1'b1;
        t0 = trig_cnt;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 4);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 4);
        drain("bp");
        check("bp_trig_count", trig_cnt - t0, 2);
        rdy_rand = 1'b0;

        // Key write while the core runs is dropped
        core_lat = 6;
        send_block(FIPS_PT, 1'b0, 1'b1, 4);
        wait_state(ST_WAIT_DONE, "kp_reach_wait_done");
        write_key(2'd0, 32'hffffffff, 1'b0);
        check("kp_key_held", TOP_key, model_key());
        drain("kp");
        check("kp_ct_unchanged", last_blk, FIPS_CT);
        core_lat = -1;
        write_key(2'd0, 32'hffffffff, 1'b1);
        check("kp_key_taken", TOP_key, model_key());
        send_block(FIPS_PT, 1'b0, 1'b1, 4);
        drain("kp2");
        check("kp_ct_changed", last_blk == FIPS_CT, 1'b0);

        // Watchdog: core never starts
        core_mode = MODE_DEAD;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 4);
        @(negedge clk);
        check("wd0_trig", sample_trig_top, 1'b1);
        repeat (TB_TIMEOUT) @(negedge clk);
        check("wd0_err_before", err, 1'b0);
        @(negedge clk);
        check("wd0_err_set", err, 1'b1);
        check("wd0_state", state_dbg, ST_COLLECT);
        check("wd0_in_ready", sif.in_ready, 1'b1);
        @(negedge clk);
        check("wd0_err_sticky", err, 1'b1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("wd0_err_clr", err, 1'b0);
        @(posedge clk); #1;

        // Watchdog: core stuck busy; clear held across the timeout edge
        core_mode = MODE_STUCK;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 4);
        @(negedge clk);
        check("wd1_trig", sample_trig_top, 1'b1);
        repeat (TB_TIMEOUT + 1) @(negedge clk);
        check("wd1_state_wait_done", state_dbg, ST_WAIT_DONE);
        check("wd1_err_before", err, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        check("wd1_err_set_priority", err, 1'b1);
        check("wd1_state", state_dbg, ST_COLLECT);
        @(negedge clk);
        check("wd1_err_clr", err, 1'b0);
        err_clr = 1'b0;
        core_mode = MODE_NORMAL;
        @(posedge clk); #1;

        // Reset after two words
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 2);
        pulse_reset();
        check_idle("rst2w");

        // Reset while the core is busy: no later start pulse
        for (int i = 0; i < 4; i++) write_key(2'(i), $urandom, 1'b1);
        core_lat = 6;
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 4);
        wait_state(ST_WAIT_DONE, "rstwd_reach_wait_done");
        pulse_reset();
        check_idle("rstwd");
        t0 = trig_cnt;
        repeat (12) @(negedge clk);
        check("rstwd_no_trig", trig_cnt - t0, 0);
        check("rstwd_no_valid", sif.out_valid, 1'b0);
        @(posedge clk); #1;
        core_lat = -1;

        // Fresh key and block after reset
        for (int i = 0; i < 4; i++) write_key(2'(i), $urandom, 1'b1);
        check("post_rst_key", TOP_key, model_key());
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 1'b1, 1'b1, 4);
        drain("post_rst");
        check("post_rst_ct", last_blk, aes_enc(model_key(), pt));
        check("final_err", err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
